// File: rtl/uncache_queue_if.sv
// Bundle of all handshake/bus signals of the uncached access queue.
//   enq_*      : op offer from the load/store pipeline (+ addr_is_mmio decode)
//   flush_*    : redirect, kills entries younger than the given robidx
//   uc_req_*   : request channel towards the trinity bus
//   uc_resp_*  : bus completion pulse and read data
//   wb_*       : writeback beat towards the backend
//   q_count    : number of occupied queue entries
// slave is the queue side, master is the environment side.
interface uncache_queue_if #(
   parameter int DEPTH   = 4,
   parameter int XLEN    = 64,
   parameter int PREG_W  = 6,
   parameter int ROB_LOG = 6
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic               enq_valid;
   logic               enq_ready;
   logic               enq_is_load;
   logic               enq_is_unsigned;
   logic [XLEN-1:0]    enq_addr;
   logic [XLEN-1:0]    enq_wdata;
   logic [3:0]         enq_ls_size;
   logic [PREG_W-1:0]  enq_prd;
   logic               enq_robidx_flag;
   logic [ROB_LOG-1:0] enq_robidx;
   logic               addr_is_mmio;
   logic               flush_valid;
   logic               flush_robidx_flag;
   logic [ROB_LOG-1:0] flush_robidx;
   logic               uc_req_valid;
   logic               uc_req_ready;
   logic [XLEN-1:0]    uc_req_addr;
   logic [XLEN-1:0]    uc_req_wdata;
   logic [XLEN-1:0]    uc_req_wmask;
   logic [1:0]         uc_req_optype;
   logic               uc_resp_done;
   logic [XLEN-1:0]    uc_resp_rdata;
   logic               wb_valid;
   logic               wb_ready;
   logic               wb_need_to_wb;
   logic [PREG_W-1:0]  wb_prd;
   logic               wb_robidx_flag;
   logic [ROB_LOG-1:0] wb_robidx;
   logic               wb_mmio;
   logic [XLEN-1:0]    wb_data;
   logic [CW-1:0]      q_count;

   modport slave (
      input  enq_valid, enq_is_load, enq_is_unsigned, enq_addr, enq_wdata,
             enq_ls_size, enq_prd, enq_robidx_flag, enq_robidx,
             flush_valid, flush_robidx_flag, flush_robidx,
             uc_req_ready, uc_resp_done, uc_resp_rdata, wb_ready,
      output enq_ready, addr_is_mmio, uc_req_valid, uc_req_addr, uc_req_wdata,
             uc_req_wmask, uc_req_optype, wb_valid, wb_need_to_wb, wb_prd,
             wb_robidx_flag, wb_robidx, wb_mmio, wb_data, q_count
   );

   modport master (
      output enq_valid, enq_is_load, enq_is_unsigned, enq_addr, enq_wdata,
             enq_ls_size, enq_prd, enq_robidx_flag, enq_robidx,
             flush_valid, flush_robidx_flag, flush_robidx,
             uc_req_ready, uc_resp_done, uc_resp_rdata, wb_ready,
      input  enq_ready, addr_is_mmio, uc_req_valid, uc_req_addr, uc_req_wdata,
             uc_req_wmask, uc_req_optype, wb_valid, wb_need_to_wb, wb_prd,
             wb_robidx_flag, wb_robidx, wb_mmio, wb_data, q_count
   );
endinterface

// File: rtl/uncache_queue.sv
// In-order MMIO/uncached access queue. Ops are queued, issued one at a
// time (head only) over the bus request channel, and retired through a
// writeback beat. Redirect flushes mark younger entries killed; killed
// entries are popped without bus activity or writeback.
// Ports: clock, reset (async, active high), io (uncache_queue_if.slave).
module uncache_queue #(
   parameter int               DEPTH      = 4,
   parameter int               XLEN       = 64,
   parameter int               PREG_W     = 6,
   parameter int               ROB_LOG    = 6,
   parameter logic [XLEN-1:0]  MMIO_BASE  = XLEN'(64'h3000_0000),
   parameter logic [XLEN-1:0]  MMIO_LIMIT = XLEN'(64'h4070_0000)
) (
   input  logic              clock,
   input  logic              reset,
   uncache_queue_if.slave    io
);
   localparam int IW    = $clog2(DEPTH);
   localparam int PW    = IW + 1;
   localparam int OFF_W = $clog2(XLEN / 8);
   localparam int SH_W  = $clog2(XLEN);

   typedef struct packed {
      logic               is_load;
      logic               is_unsigned;
      logic [XLEN-1:0]    addr;
      logic [XLEN-1:0]    wdata;
      logic [3:0]         ls_size;
      logic [PREG_W-1:0]  prd;
      logic               flag;
      logic [ROB_LOG-1:0] robidx;
   } entry_t;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

   entry_t           q [DEPTH];
   logic [DEPTH-1:0] killed;
   logic [PW-1:0]    head, tail;
   state_t           state;

   function automatic logic younger(input logic ff, input logic [ROB_LOG-1:0] fi,
                                    input logic ef, input logic [ROB_LOG-1:0] ei);
      return (ff ^ ef) ^ (fi < ei);
   endfunction

   function automatic logic [XLEN-1:0] size_mask(input logic [3:0] sz);
      logic [XLEN-1:0] m;
      if (sz[3])      m = '1;
      else if (sz[2]) m = {{(XLEN-32){1'b0}}, {32{1'b1}}};
      else if (sz[1]) m = {{(XLEN-16){1'b0}}, {16{1'b1}}};
      else            m = {{(XLEN-8){1'b0}},  {8{1'b1}}};
      return m;
   endfunction

   function automatic logic [SH_W-1:0] byte_shift(input logic [XLEN-1:0] a);
      return {a[OFF_W-1:0], 3'b000};
   endfunction

   function automatic logic [XLEN-1:0] fmt_load(input entry_t e, input logic [XLEN-1:0] rd);
      logic [XLEN-1:0] v, m;
      logic            s;
      v = rd >> byte_shift(e.addr);
      m = size_mask(e.ls_size);
      s = e.ls_size[2] ? v[31] : (e.ls_size[1] ? v[15] : v[7]);
      if (e.ls_size[3]) return v;
      return (v & m) | ((s && !e.is_unsigned) ? ~m : '0);
   endfunction

   logic [IW-1:0] hidx, tidx;
   logic          full, empty, enq_fire, enq_kill, head_kill_now, head_dead, issue_ok;
   entry_t        enq_e, head_e, req_src;

   assign hidx  = head[IW-1:0];
   assign tidx  = tail[IW-1:0];
   assign full  = (hidx == tidx) && (head[IW] != tail[IW]);
   assign empty = (head == tail);

   assign enq_e = '{is_load: io.enq_is_load, is_unsigned: io.enq_is_unsigned,
                    addr: io.enq_addr, wdata: io.enq_wdata, ls_size: io.enq_ls_size,
                    prd: io.enq_prd, flag: io.enq_robidx_flag, robidx: io.enq_robidx};

   assign enq_fire      = io.enq_valid && !full;
   assign enq_kill      = io.flush_valid &&
                          younger(io.flush_robidx_flag, io.flush_robidx, enq_e.flag, enq_e.robidx);
   assign head_e        = q[hidx];
   assign head_kill_now = io.flush_valid &&
                          younger(io.flush_robidx_flag, io.flush_robidx, head_e.flag, head_e.robidx);
   assign head_dead     = killed[hidx] || head_kill_now;

   // An empty queue issues straight from the enqueue port so the request
   // appears the cycle after the op is accepted.
   assign req_src  = empty ? enq_e : head_e;
   assign issue_ok = empty ? (enq_fire && !enq_kill) : !head_dead;

   assign io.enq_ready    = !full;
   assign io.addr_is_mmio = (io.enq_addr >= MMIO_BASE) && (io.enq_addr <= MMIO_LIMIT);
   assign io.q_count      = tail - head;
   assign io.wb_mmio      = io.wb_valid;

   // Payload storage needs no reset; occupancy lives in the pointers.
   always_ff @(posedge clock) begin
      if (enq_fire) q[tidx] <= enq_e;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state             <= S_IDLE;
         head              <= '0;
         tail              <= '0;
         killed            <= '0;
         io.uc_req_valid   <= 1'b0;
         io.uc_req_addr    <= '0;
         io.uc_req_wdata   <= '0;
         io.uc_req_wmask   <= '0;
         io.uc_req_optype  <= 2'b00;
         io.wb_valid       <= 1'b0;
         io.wb_need_to_wb  <= 1'b0;
         io.wb_prd         <= '0;
         io.wb_robidx_flag <= 1'b0;
         io.wb_robidx      <= '0;
         io.wb_data        <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (io.flush_valid && younger(io.flush_robidx_flag, io.flush_robidx, q[i].flag, q[i].robidx))
               killed[i] <= 1'b1;
         if (enq_fire) begin
            tail         <= tail + 1'b1;
            killed[tidx] <= enq_kill;
         end

         unique case (state)
            S_IDLE: begin
               if (!empty && head_dead) begin
                  head <= head + 1'b1;
               end else if (issue_ok) begin
                  state            <= S_REQ;
                  io.uc_req_valid  <= 1'b1;
                  io.uc_req_addr   <= req_src.addr;
                  io.uc_req_wdata  <= req_src.wdata << byte_shift(req_src.addr);
                  io.uc_req_wmask  <= req_src.ls_size[3] ? '1 :
                                      (size_mask(req_src.ls_size) << byte_shift(req_src.addr));
                  io.uc_req_optype <= req_src.is_load ? 2'b00 : 2'b01;
               end
            end
            S_REQ: begin
               if (io.uc_req_ready) begin
                  io.uc_req_valid <= 1'b0;
                  state           <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (io.uc_resp_done) begin
                  if (head_dead) begin
                     head  <= head + 1'b1;
                     state <= S_IDLE;
                  end else begin
                     state             <= S_WB;
                     io.wb_valid       <= 1'b1;
                     io.wb_need_to_wb  <= head_e.is_load;
                     io.wb_prd         <= head_e.prd;
                     io.wb_robidx_flag <= head_e.flag;
                     io.wb_robidx      <= head_e.robidx;
                     io.wb_data        <= head_e.is_load ? fmt_load(head_e, io.uc_resp_rdata) : '0;
                  end
               end
            end
            S_WB: begin
               // Either retirement or a late kill frees the head.
               if (io.wb_ready || head_kill_now) begin
                  io.wb_valid <= 1'b0;
                  head        <= head + 1'b1;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uncache_queue.sv
module tb_uncache_queue;
   localparam int DEPTH = 4;
   localparam logic [63:0] BASE  = 64'h3000_0000;
   localparam logic [63:0] LIMIT = 64'h4070_0000;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   uncache_queue_if #(.DEPTH(DEPTH), .XLEN(64), .PREG_W(6), .ROB_LOG(6)) u_if ();
   uncache_queue #(.DEPTH(DEPTH), .XLEN(64), .PREG_W(6), .ROB_LOG(6)) dut (
      .clock(clock), .reset(reset), .io(u_if.slave));

   int n_err = 0;
   int n_chk = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   typedef struct {
      bit          ld, uns;
      logic [63:0] addr, wdata;
      int          nb;
      logic [5:0]  prd;
      bit          flag;
      logic [5:0]  rob;
   } op_t;

   // Reference formatting from byte counts and offsets.
   function automatic logic [63:0] nb_mask(input int nb);
      return (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << (8 * nb)) - 64'h1);
   endfunction

   function automatic logic [63:0] exp_load(input op_t o, input logic [63:0] rd);
      logic [63:0] v, m;
      int          off;
      off = int'(o.addr % 8);
      v = rd >> (8 * off);
      if (o.nb == 8) return v;
      m = nb_mask(o.nb);
      v = v & m;
      if (!o.uns && v[8*o.nb-1]) v = v | ~m;
      return v;
   endfunction

   task automatic cyc;
      @(posedge clock); #1;
   endtask

   task automatic enq(input bit ld, input bit uns, input logic [63:0] addr, input logic [63:0] wd,
                      input logic [3:0] sz, input logic [5:0] rob, input bit flag);
      u_if.enq_valid = 1'b1; u_if.enq_is_load = ld; u_if.enq_is_unsigned = uns;
      u_if.enq_addr = addr; u_if.enq_wdata = wd; u_if.enq_ls_size = sz;
      u_if.enq_prd = rob; u_if.enq_robidx = rob; u_if.enq_robidx_flag = flag;
      cyc();
      u_if.enq_valid = 1'b0;
   endtask

   // Waits (bounded) for a request, checks its address, completes it and
   // checks whether a writeback beat follows.
   task automatic serve_one(input logic [63:0] addr, input logic [5:0] rob, input bit exp_wb);
      int n = 0;
      @(negedge clock);
      while (!u_if.uc_req_valid && n < 20) begin @(negedge clock); n++; end
      chk("req_timeout", 64'(n >= 20), 64'd0);
      chk("req_addr", u_if.uc_req_addr, addr);
      u_if.uc_req_ready = 1'b1;
      cyc();
      u_if.uc_req_ready = 1'b0;
      u_if.uc_resp_done = 1'b1; u_if.uc_resp_rdata = 64'h1122_3344_5566_7788;
      cyc();
      u_if.uc_resp_done = 1'b0;
      @(negedge clock);
      chk("wb_valid", 64'(u_if.wb_valid), 64'(exp_wb));
      if (exp_wb) begin
         chk("wb_robidx", 64'(u_if.wb_robidx), 64'(rob));
         u_if.wb_ready = 1'b1;
         cyc();
         u_if.wb_ready = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      op_t         mq [$];
      op_t         o;
      int          n, reqs, pend, dly, sz_i, off, cnt;
      logic [63:0] exp_wbd, a;
      logic [6:0]  rob_ctr;
      bit          done_now;

      u_if.enq_valid = 0; u_if.enq_is_load = 0; u_if.enq_is_unsigned = 0;
      u_if.enq_addr = '0; u_if.enq_wdata = '0; u_if.enq_ls_size = 4'b0001;
      u_if.enq_prd = '0; u_if.enq_robidx_flag = 0; u_if.enq_robidx = '0;
      u_if.flush_valid = 0; u_if.flush_robidx_flag = 0; u_if.flush_robidx = '0;
      u_if.uc_req_ready = 0; u_if.uc_resp_done = 0; u_if.uc_resp_rdata = '0;
      u_if.wb_ready = 0;

      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_req_valid", 64'(u_if.uc_req_valid), 64'd0);
      chk("rst_wb_valid", 64'(u_if.wb_valid), 64'd0);
      chk("rst_q_count", 64'(u_if.q_count), 64'd0);
      chk("rst_wb_data", u_if.wb_data, 64'd0);
      chk("rst_optype", 64'(u_if.uc_req_optype), 64'd0);
      cyc();
      reset = 1'b0;
      cyc();

      // Signed word load at offset 4; request must appear the next cycle
      enq(1, 0, 64'h3000_0004, 64'd0, 4'b0100, 6'd1, 0);
      @(negedge clock);
      chk("ld_req_lat", 64'(u_if.uc_req_valid), 64'd1);
      chk("ld_optype", 64'(u_if.uc_req_optype), 64'd0);
      chk("ld_addr", u_if.uc_req_addr, 64'h3000_0004);
      u_if.uc_req_ready = 1'b1;
      cyc();
      u_if.uc_req_ready = 1'b0;
      u_if.uc_resp_done = 1'b1; u_if.uc_resp_rdata = 64'h8000_0001_DEAD_BEEF;
      cyc();
      u_if.uc_resp_done = 1'b0;
      @(negedge clock);
      chk("ld_wb_valid", 64'(u_if.wb_valid), 64'd1);
      chk("ld_wb_data", u_if.wb_data, 64'hFFFF_FFFF_8000_0001);
      chk("ld_need_wb", 64'(u_if.wb_need_to_wb), 64'd1);
      chk("ld_mmio", 64'(u_if.wb_mmio), 64'd1);
      u_if.wb_ready = 1'b1;
      cyc();
      u_if.wb_ready = 1'b0;
      @(negedge clock);
      chk("ld_pop", 64'(u_if.q_count), 64'd0);

      // Halfword store at offset 2
      cyc();
      enq(0, 0, 64'h3000_0002, 64'hBEEF, 4'b0010, 6'd2, 0);
      @(negedge clock);
      chk("st_wdata", u_if.uc_req_wdata, 64'hBEEF_0000);
      chk("st_wmask", u_if.uc_req_wmask, 64'h0000_0000_FFFF_0000);
      chk("st_optype", 64'(u_if.uc_req_optype), 64'd1);
      u_if.uc_req_ready = 1'b1;
      cyc();
      u_if.uc_req_ready = 1'b0;
      u_if.uc_resp_done = 1'b1;
      cyc();
      u_if.uc_resp_done = 1'b0;
      @(negedge clock);
      chk("st_wb_valid", 64'(u_if.wb_valid), 64'd1);
      chk("st_need_wb", 64'(u_if.wb_need_to_wb), 64'd0);
      chk("st_wb_data", u_if.wb_data, 64'd0);
      u_if.wb_ready = 1'b1;
      cyc();
      u_if.wb_ready = 1'b0;

      // Fill to DEPTH with the bus stalled, then drain in order
      for (int i = 0; i < DEPTH; i++)
         enq(1, 0, BASE + 64'h100 * i, 64'd0, 4'b1000, 6'(10 + i), 0);
      @(negedge clock);
      chk("full_count", 64'(u_if.q_count), 64'(DEPTH));
      chk("full_ready", 64'(u_if.enq_ready), 64'd0);
      enq(1, 0, BASE + 64'h800, 64'd0, 4'b1000, 6'd40, 0);
      @(negedge clock);
      chk("full_no_enq", 64'(u_if.q_count), 64'(DEPTH));
      for (int i = 0; i < DEPTH; i++)
         serve_one(BASE + 64'h100 * i, 6'(10 + i), 1);

      // Flush robidx 3 while head (3) is in WAIT: 4 and 5 die silently
      cyc();
      for (int i = 0; i < 3; i++) enq(1, 0, BASE + 64'h40 * i, 64'd0, 4'b1000, 6'(3 + i), 0);
      @(negedge clock);
      u_if.uc_req_ready = 1'b1;
      cyc();
      u_if.uc_req_ready = 1'b0;
      u_if.flush_valid = 1'b1; u_if.flush_robidx = 6'd3; u_if.flush_robidx_flag = 1'b0;
      cyc();
      u_if.flush_valid = 1'b0;
      u_if.uc_resp_done = 1'b1;
      cyc();
      u_if.uc_resp_done = 1'b0;
      @(negedge clock);
      chk("fl_head_wb", 64'(u_if.wb_valid), 64'd1);
      chk("fl_head_rob", 64'(u_if.wb_robidx), 64'd3);
      u_if.wb_ready = 1'b1;
      cyc();
      u_if.wb_ready = 1'b0;
      reqs = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         reqs += int'(u_if.uc_req_valid);
      end
      chk("fl_no_req", 64'(reqs), 64'd0);
      chk("fl_count", 64'(u_if.q_count), 64'd0);

      // Flush kills the head in WAIT; a later op must still be issued
      cyc();
      enq(1, 0, 64'h3000_0A00, 64'd0, 4'b1000, 6'd20, 0);
      @(negedge clock);
      u_if.uc_req_ready = 1'b1;
      cyc();
      u_if.uc_req_ready = 1'b0;
      u_if.flush_valid = 1'b1; u_if.flush_robidx = 6'd19; u_if.flush_robidx_flag = 1'b0;
      cyc();
      u_if.flush_valid = 1'b0;
      enq(1, 0, 64'h3000_0B00, 64'd0, 4'b1000, 6'd20, 0);
      u_if.uc_resp_done = 1'b1;
      cyc();
      u_if.uc_resp_done = 1'b0;
      @(negedge clock);
      chk("kh_no_wb", 64'(u_if.wb_valid), 64'd0);
      serve_one(64'h3000_0B00, 6'd20, 1);

      // Reset during WAIT; a stale done afterwards is ignored
      cyc();
      enq(1, 0, 64'h3000_0C00, 64'd0, 4'b1000, 6'd30, 0);
      @(negedge clock);
      u_if.uc_req_ready = 1'b1;
      cyc();
      u_if.uc_req_ready = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("rw_req_valid", 64'(u_if.uc_req_valid), 64'd0);
      chk("rw_count", 64'(u_if.q_count), 64'd0);
      cyc();
      reset = 1'b0;
      u_if.uc_resp_done = 1'b1;
      cyc();
      u_if.uc_resp_done = 1'b0;
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         cnt += int'(u_if.wb_valid) + int'(u_if.uc_req_valid);
      end
      chk("rw_ignored", 64'(cnt), 64'd0);
      cyc();

      // Randomized traffic against a transaction-level queue model
      rob_ctr = '0; pend = 0; dly = 0; exp_wbd = '0;
      for (int c = 0; c < 1400; c++) begin
         sz_i = int'($urandom % 4);
         off  = int'($urandom % 8) & ~((1 << sz_i) - 1);
         u_if.enq_valid       = (c < 1000) && ($urandom % 2 == 1);
         u_if.enq_is_load     = $urandom % 2;
         u_if.enq_is_unsigned = $urandom % 2;
         u_if.enq_ls_size     = 4'(1 << sz_i);
         u_if.enq_wdata       = {$urandom, $urandom};
         u_if.enq_prd         = 6'($urandom);
         u_if.enq_robidx      = rob_ctr[5:0];
         u_if.enq_robidx_flag = rob_ctr[6];
         if (u_if.enq_valid) begin
            u_if.enq_addr = BASE + 64'(($urandom % 4096) * 8) + 64'(off);
         end else begin
            case ($urandom % 5)
               0: u_if.enq_addr = BASE - 1;
               1: u_if.enq_addr = BASE;
               2: u_if.enq_addr = LIMIT;
               3: u_if.enq_addr = LIMIT + 1;
               default: u_if.enq_addr = {$urandom, $urandom};
            endcase
         end
         u_if.uc_req_ready  = $urandom % 2;
         u_if.wb_ready      = $urandom % 2;
         done_now           = (pend != 0) && (dly == 0);
         u_if.uc_resp_done  = done_now;
         u_if.uc_resp_rdata = {$urandom, $urandom};
         @(negedge clock);
         chk("rnd_count", 64'(u_if.q_count), 64'(mq.size()));
         if (!u_if.enq_valid) begin
            a = u_if.enq_addr;
            chk("rnd_mmio", 64'(u_if.addr_is_mmio), 64'(a >= BASE && a <= LIMIT));
         end
         if (done_now) begin
            pend = 0;
            if (mq.size() > 0) exp_wbd = mq[0].ld ? exp_load(mq[0], u_if.uc_resp_rdata) : 64'd0;
         end else if (pend != 0) begin
            dly--;
         end
         if (u_if.uc_req_valid && u_if.uc_req_ready) begin
            if (mq.size() == 0) begin
               chk("rnd_req_unexp", 64'd1, 64'd0);
            end else begin
               o = mq[0];
               chk("rnd_req_addr", u_if.uc_req_addr, o.addr);
               chk("rnd_req_optype", 64'(u_if.uc_req_optype), o.ld ? 64'd0 : 64'd1);
               if (!o.ld) begin
                  chk("rnd_req_wdata", u_if.uc_req_wdata, o.wdata << (8 * (o.addr % 8)));
                  chk("rnd_req_wmask", u_if.uc_req_wmask,
                      (o.nb == 8) ? nb_mask(8) : (nb_mask(o.nb) << (8 * (o.addr % 8))));
               end
            end
            pend = 1;
            dly  = int'($urandom % 4);
         end
         if (u_if.wb_valid && u_if.wb_ready) begin
            if (mq.size() == 0) begin
               chk("rnd_wb_unexp", 64'd1, 64'd0);
            end else begin
               o = mq.pop_front();
               chk("rnd_wb_rob", 64'({u_if.wb_robidx_flag, u_if.wb_robidx}), 64'({o.flag, o.rob}));
               chk("rnd_wb_prd", 64'(u_if.wb_prd), 64'(o.prd));
               chk("rnd_wb_need", 64'(u_if.wb_need_to_wb), 64'(o.ld));
               chk("rnd_wb_data", u_if.wb_data, exp_wbd);
            end
         end
         if (u_if.enq_valid && u_if.enq_ready) begin
            o.ld = u_if.enq_is_load; o.uns = u_if.enq_is_unsigned;
            o.addr = u_if.enq_addr; o.wdata = u_if.enq_wdata; o.nb = 1 << sz_i;
            o.prd = u_if.enq_prd; o.flag = rob_ctr[6]; o.rob = rob_ctr[5:0];
            mq.push_back(o);
            rob_ctr++;
         end
         cyc();
      end
      u_if.enq_valid = 0; u_if.uc_req_ready = 0; u_if.wb_ready = 0; u_if.uc_resp_done = 0;
      @(negedge clock);
      chk("rnd_drained", 64'(mq.size()), 64'd0);
      chk("rnd_final_count", 64'(u_if.q_count), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
